// File: rtl/tiny_mem_arbiter.sv
// tiny_mem_arbiter: shares one tiny-core memory bus between two masters,
// one registered slave transaction at a time, with a wait watchdog.
module tiny_mem_arbiter #(
  parameter bit          PRIO_M1        = 1'b0,
  parameter int          TIMEOUT_CYCLES = 64,
  parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_valid_i,
  input  logic        m0_we_i,
  input  logic [31:0] m0_addr_i,
  input  logic [31:0] m0_wdata_i,
  input  logic [3:0]  m0_wstrb_i,
  output logic        m0_ready_o,
  output logic [31:0] m0_rdata_o,
  input  logic        m1_valid_i,
  input  logic        m1_we_i,
  input  logic [31:0] m1_addr_i,
  input  logic [31:0] m1_wdata_i,
  input  logic [3:0]  m1_wstrb_i,
  output logic        m1_ready_o,
  output logic [31:0] m1_rdata_o,
  output logic        s_valid_o,
  output logic        s_we_o,
  output logic [31:0] s_addr_o,
  output logic [31:0] s_wdata_o,
  output logic [3:0]  s_wstrb_o,
  input  logic        s_ready_i,
  input  logic [31:0] s_rdata_i,
  output logic [1:0]  grant_o,
  output logic        timeout_err_o
);
  localparam int CW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t      state_q, state_d;
  logic        last_m1_q, last_m1_d;
  logic [1:0]  grant_q, grant_d;
  logic        s_valid_q, s_valid_d, s_we_q, s_we_d;
  logic [31:0] s_addr_q, s_addr_d, s_wdata_q, s_wdata_d;
  logic [3:0]  s_wstrb_q, s_wstrb_d;
  logic [31:0] m0_rdata_q, m0_rdata_d, m1_rdata_q, m1_rdata_d;
  logic        m0_ready_q, m0_ready_d, m1_ready_q, m1_ready_d;
  logic        timeout_q, timeout_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        pick_m1, expire;
  logic [31:0] rsp;

  // m1 wins if alone, if prioritised, or if m0 owned the bus last
  assign pick_m1 = m1_valid_i & (~m0_valid_i | PRIO_M1 | ~last_m1_q);
  assign expire  = TIMEOUT_CYCLES != 0 && int'(cnt_q) == TIMEOUT_CYCLES - 1;
  assign rsp     = s_ready_i ? s_rdata_i : ERR_DATA;

  always_comb begin
    state_d    = state_q;
    last_m1_d  = last_m1_q;
    grant_d    = grant_q;
    s_valid_d  = s_valid_q;
    s_we_d     = s_we_q;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    s_wstrb_d  = s_wstrb_q;
    m0_rdata_d = m0_rdata_q;
    m1_rdata_d = m1_rdata_q;
    m0_ready_d = 1'b0;
    m1_ready_d = 1'b0;
    timeout_d  = timeout_q;
    cnt_d      = cnt_q;
    case (state_q)
      IDLE: if (m0_valid_i | m1_valid_i) begin
        state_d   = BUSY;
        s_valid_d = 1'b1;
        grant_d   = pick_m1 ? 2'b10 : 2'b01;
        last_m1_d = pick_m1;
        cnt_d     = '0;
        s_we_d    = pick_m1 ? m1_we_i : m0_we_i;
        s_addr_d  = pick_m1 ? m1_addr_i : m0_addr_i;
        s_wdata_d = pick_m1 ? m1_wdata_i : m0_wdata_i;
        s_wstrb_d = pick_m1 ? m1_wstrb_i : m0_wstrb_i;
      end
      BUSY: if (s_ready_i || expire) begin
        state_d    = RESP;
        s_valid_d  = 1'b0;
        m0_rdata_d = grant_q[0] ? rsp : m0_rdata_q;
        m1_rdata_d = grant_q[1] ? rsp : m1_rdata_q;
        m0_ready_d = grant_q[0];
        m1_ready_d = grant_q[1];
        timeout_d  = timeout_q | ~s_ready_i;
      end else if (cnt_q != '1) begin
        cnt_d = cnt_q + 1'b1;
      end
      RESP: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_m1_q  <= 1'b1;
      grant_q    <= '0;
      s_valid_q  <= 1'b0;
      s_we_q     <= 1'b0;
      s_addr_q   <= '0;
      s_wdata_q  <= '0;
      s_wstrb_q  <= '0;
      m0_rdata_q <= '0;
      m1_rdata_q <= '0;
      m0_ready_q <= 1'b0;
      m1_ready_q <= 1'b0;
      timeout_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      last_m1_q  <= last_m1_d;
      grant_q    <= grant_d;
      s_valid_q  <= s_valid_d;
      s_we_q     <= s_we_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      s_wstrb_q  <= s_wstrb_d;
      m0_rdata_q <= m0_rdata_d;
      m1_rdata_q <= m1_rdata_d;
      m0_ready_q <= m0_ready_d;
      m1_ready_q <= m1_ready_d;
      timeout_q  <= timeout_d;
      cnt_q      <= cnt_d;
    end
  end

  assign m0_ready_o    = m0_ready_q;
  assign m0_rdata_o    = m0_rdata_q;
  assign m1_ready_o    = m1_ready_q;
  assign m1_rdata_o    = m1_rdata_q;
  assign s_valid_o     = s_valid_q;
  assign s_we_o        = s_we_q;
  assign s_addr_o      = s_addr_q;
  assign s_wdata_o     = s_wdata_q;
  assign s_wstrb_o     = s_wstrb_q;
  assign grant_o       = grant_q;
  assign timeout_err_o = timeout_q;
endmodule

// File: doc/tiny_mem_arbiter.md
Name: tiny_mem_arbiter

Overview:
Two-master arbiter that shares one tiny-core-style memory bus (valid/we/addr/wdata/wstrb/ready/rdata) between the tiny_thumb_core (m0) and a secondary master (m1, e.g. program loader or debug DMA). It sits between both masters and tiny_mem_model. It registers the winning request, issues exactly one slave transaction at a time, and returns a registered one-cycle ready/rdata response to the granted master. A watchdog terminates transactions the slave never acknowledges.

Parameters:
PRIO_M1, 0, 0 = round-robin between m0/m1; 1 = m1 always wins simultaneous requests
TIMEOUT_CYCLES, 64, slave-wait cycles before forced termination; 0 disables the watchdog
ERR_DATA, 32'hDEAD_BEEF, rdata returned to the master on timeout

Ports:
clk  in  1  clock
rst_n  in  1  reset; one clock; reset is asynchronous and active-low
m0_valid  in  1  m0 request, held until m0_ready
m0_we  in  1  m0 write enable
m0_addr  in  32  m0 byte address
m0_wdata  in  32  m0 write data
m0_wstrb  in  4  m0 byte strobes
m0_ready  out  1  one-cycle completion pulse to m0
m0_rdata  out  32  read data to m0, valid while m0_ready=1
m1_valid, m1_we, m1_addr, m1_wdata, m1_wstrb  in  1/1/32/32/4  m1 request, same rules as m0
m1_ready  out  1  one-cycle completion pulse to m1
m1_rdata  out  32  read data to m1
s_valid  out  1  slave request
s_we  out  1  slave write enable
s_addr  out  32  slave address
s_wdata  out  32  slave write data
s_wstrb  out  4  slave strobes
s_ready  in  1  slave completion
s_rdata  in  32  slave read data, sampled when s_ready=1
grant  out  2  one-hot owner of the current transaction; 2'b00 when IDLE
timeout_err  out  1  sticky: set on any watchdog timeout, cleared only by reset

Behaviour:
- Reset: all outputs 0, including s_* bus, m*_rdata, grant and timeout_err; state=IDLE; last_grant=m1, so m0 wins the first tie.
- States are IDLE, BUSY and RESP.
- IDLE: if neither valid is high, stay in IDLE. Otherwise select a winner.
  - One requester: that master wins.
  - Both, with PRIO_M1=1: m1 wins.
  - Both, with PRIO_M1=0: the master not equal to last_grant wins.
  - At the clock edge: latch the winner's we/addr/wdata/wstrb into s_* registers, set s_valid=1, set grant, update last_grant, clear the wait counter, go to BUSY.
- BUSY: s_* outputs held stable; s_valid=1.
  - When s_ready=1: capture s_rdata into the winner's m*_rdata, s_valid<=0, go to RESP.
  - When s_ready=0: increment the wait counter. When TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES-1, load m*_rdata<=ERR_DATA, set timeout_err, s_valid<=0, go to RESP.
  - s_ready while IDLE or RESP is ignored.
- RESP: the granted master's m*_ready=1 for exactly this cycle. The other master's ready stays 0. grant is still valid. Next state is IDLE and grant<=0.
- m*_rdata holds its value until overwritten by the next transaction to the same master.
- Latency with a same-cycle slave: request seen in cycle 0 (IDLE), s_valid in cycle 1, m*_ready in cycle 2, IDLE again in cycle 3. A master that keeps valid high in cycle 3 is treated as a new request.
- The losing master's valid is never acknowledged and remains pending; it is served no later than the next arbitration under round-robin.
- Master signals are not sampled outside IDLE. Changes by the owner mid-transaction have no effect.
- Async reset mid-transaction: immediately return to IDLE with all outputs 0. No ready pulse is issued for the aborted request.
- Widths: the wait counter is $clog2(TIMEOUT_CYCLES+1) bits and never wraps.

Test Plan:
- m0 read addr 0x100, slave ready the cycle after s_valid with rdata 0x12345678 -> s_addr=0x100 and s_we=0; m0_ready pulses once with m0_rdata=0x12345678; grant=01 during the transaction; m1_ready never asserts.
- m0 and m1 both request continuously, PRIO_M1=0, slave always ready -> grants alternate m0,m1,m0,m1 (m0 first); each master gets one ready per 3-cycle transaction.
- Same stimulus with PRIO_M1=1 -> m1 is granted every transaction; m0 is never served while m1_valid stays high.
- m1 write addr 0x104, wdata 0xCAFEF00D, wstrb 4'b0011 -> s_we=1, s_wstrb=0011, s_wdata=0xCAFEF00D stable while BUSY; m1_ready pulses once.
- TIMEOUT_CYCLES=4, slave never ready -> s_valid high for exactly 4 cycles, then m0_ready pulses with m0_rdata=0xDEADBEEF; timeout_err=1 and stays set through later good transactions.
- rst_n asserted in BUSY -> s_valid, grant and ready outputs drop to 0 asynchronously. After release, a pending m0 request is re-arbitrated and completes normally.
